comb_sweep_ctrl: RTL and testbench

Sweeps the 4-bit input vector {D,C,B,A} through an exhaustive range and feeds it to the four implementations of the 4-input combinational function: structural, dataflow, behavioural and primitive. After a settle time it samples all four outputs and checks that they agree. It records the function's truth table, counts mismatches and reports pass/fail through a start/busy/done handshake. It is the synthesizable on-chip replacement for the free-running stimulus loop used to exercise the four function models.

---
 rtl/comb_sweep_ctrl.sv | 178 +++++++++++++++++
 tb/tb_comb_sweep_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_sweep_ctrl.sv
// Exhaustive sweep of {D,C,B,A} across four models of one 4-input function; logs truth table and mismatches.
// Build option: COMB_SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module comb_sweep_ctrl #(
    parameter int unsigned LOOP   = 15,
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        res_str,
    input  logic        res_dataflow,
    input  logic        res_behavior,
    input  logic        res_prim,
    output logic [3:0]  dcba,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic        first_err_vld,
    output logic [3:0]  first_err_vec,
    output logic [15:0] truth
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_VEC    = 4'(LOOP);
    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);
    localparam logic [4:0] ERR_MAX     = 5'd16;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_settle_cnt;
    logic [3:0]  r_dcba;
    logic        r_pass;
    logic [4:0]  r_err_cnt;
    logic        r_first_err_vld;
    logic [3:0]  r_first_err_vec;
    logic [15:0] r_truth;

    logic        w_mismatch;
    logic        w_last;
    logic [4:0]  w_err_cnt_nxt;
    logic        w_init;
    logic        w_settle_inc;
    logic        w_sample;
    logic        w_advance;
    logic        w_abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_init        = 1'b0;
        w_settle_inc  = 1'b0;
        w_sample      = 1'b0;
        w_advance     = 1'b0;
        w_abort       = 1'b0;
        w_mismatch    = (res_dataflow != res_str) | (res_behavior != res_str) | (res_prim != res_str);
        w_last        = (r_dcba == LAST_VEC);
        w_err_cnt_nxt = r_err_cnt;
        if (w_mismatch && (r_err_cnt != ERR_MAX)) begin
            w_err_cnt_nxt = r_err_cnt + 5'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_init      = 1'b1;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_settle_inc = 1'b1;
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_nxt = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                // An abort here wins over the sample: the current vector is not logged.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_sample = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
`ifdef COMB_SWEEP_STOP_ON_ERR_EN
                    else if (w_mismatch) begin
                        w_state_nxt = S_DONE;
                    end
`endif
                    else begin
                        w_state_nxt = S_SETTLE;
                        w_advance   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt    <= 3'd0;
            r_dcba          <= 4'd0;
            r_pass          <= 1'b0;
            r_err_cnt       <= 5'd0;
            r_first_err_vld <= 1'b0;
            r_first_err_vec <= 4'd0;
            r_truth         <= 16'd0;
        end else begin
            if (w_init) begin
                r_settle_cnt    <= 3'd0;
                r_dcba          <= 4'd0;
                r_pass          <= 1'b0;
                r_err_cnt       <= 5'd0;
                r_first_err_vld <= 1'b0;
                r_first_err_vec <= 4'd0;
                r_truth         <= 16'd0;
            end
            if (w_abort) begin
                r_dcba <= 4'd0;
            end
            if (w_settle_inc) begin
                r_settle_cnt <= r_settle_cnt + 3'd1;
            end
            if (w_sample) begin
                r_truth[r_dcba] <= res_str;
                r_err_cnt       <= w_err_cnt_nxt;
                if (w_mismatch && !r_first_err_vld) begin
                    r_first_err_vld <= 1'b1;
                    r_first_err_vec <= r_dcba;
                end
                // Pass is resolved on entry to DONE so it is valid alongside the done pulse.
                if (w_state_nxt == S_DONE) begin
                    r_pass <= (w_err_cnt_nxt == 5'd0);
                end
            end
            if (w_advance) begin
                r_dcba       <= r_dcba + 4'd1;
                r_settle_cnt <= 3'd0;
            end
        end
    end

    assign dcba          = r_dcba;
    assign busy          = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_err_vld;
    assign first_err_vec = r_first_err_vec;
    assign truth         = r_truth;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Scoreboarded random bench for comb_sweep_ctrl: stimulus queues expected sweep results, a monitor checks each done pulse.
module tb_comb_sweep_ctrl;

    localparam int LOOP   = 15;
    localparam int SETTLE = 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        res_str;
    logic        res_dataflow;
    logic        res_behavior;
    logic        res_prim;
    logic [3:0]  dcba;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic        first_err_vld;
    logic [3:0]  first_err_vec;
    logic [15:0] truth;

    // Function under test and per-unit fault masks, indexed by the vector the DUT drives.
    logic [15:0] tb_f;
    logic [15:0] tb_m1;
    logic [15:0] tb_m2;
    logic [15:0] tb_m3;

    assign res_str      = tb_f[dcba];
    assign res_dataflow = tb_f[dcba] ^ tb_m1[dcba];
    assign res_behavior = tb_f[dcba] ^ tb_m2[dcba];
    assign res_prim     = tb_f[dcba] ^ tb_m3[dcba];

    comb_sweep_ctrl #(.LOOP(LOOP), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .res_str      (res_str),
        .res_dataflow (res_dataflow),
        .res_behavior (res_behavior),
        .res_prim     (res_prim),
        .dcba         (dcba),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_cnt      (err_cnt),
        .first_err_vld(first_err_vld),
        .first_err_vec(first_err_vec),
        .truth        (truth)
    );

    typedef struct {
        int          done_cyc;
        logic [15:0] truth;
        int          errs;
        logic        fvld;
        int          fvec;
        logic        pass;
        int          last_vec;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Walk vectors 0..nvec-1 applying the sweep rules directly.
    function automatic exp_t model(input logic [15:0] f, input logic [15:0] mism, input int nvec, input int cyc_now);
        exp_t e;
        int   nproc;
        e.truth    = '0;
        e.errs     = 0;
        e.fvld     = 1'b0;
        e.fvec     = 0;
        e.last_vec = 0;
        nproc      = 0;
        for (int v = 0; v < nvec; v++) begin
            e.truth[v] = f[v];
            e.last_vec = v;
            nproc++;
            if (mism[v]) begin
                if (e.errs < 16) e.errs++;
                if (!e.fvld) begin
                    e.fvld = 1'b1;
                    e.fvec = v;
                end
`ifdef COMB_SWEEP_STOP_ON_ERR_EN
                break;
`endif
            end
        end
        e.pass     = (e.errs == 0);
        e.done_cyc = cyc_now + 1 + nproc * (SETTLE + 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            check("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                check("truth",      32'(truth), 32'(e.truth));
                check("err_cnt",    32'(err_cnt), 32'(e.errs));
                check("first_vld",  32'(first_err_vld), 32'(e.fvld));
                check("first_vec",  32'(first_err_vec), 32'(e.fvec));
                check("pass",       32'(pass), 32'(e.pass));
                check("dcba_done",  32'(dcba), 32'(e.last_vec));
                check("busy_done",  32'(busy), 32'd0);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_dcba"},  32'(dcba), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_pass"},  32'(pass), 32'd0);
        check({tag, "_err"},   32'(err_cnt), 32'd0);
        check({tag, "_fvld"},  32'(first_err_vld), 32'd0);
        check({tag, "_fvec"},  32'(first_err_vec), 32'd0);
        check({tag, "_truth"}, 32'(truth), 32'd0);
    endtask

    task automatic run_sweep(input logic [15:0] f, input logic [15:0] m1, input logic [15:0] m2,
                             input logic [15:0] m3, input bit hold_start);
        int i;
        tb_f  = f;
        tb_m1 = m1;
        tb_m2 = m2;
        tb_m3 = m3;
        @(posedge clk);
        #1 start = 1'b1;
        sb.push_back(model(f, m1 | m2 | m3, LOOP + 1, cyc));
        if (!hold_start) begin
            @(posedge clk);
            #1 start = 1'b0;
        end else begin
            for (i = 0; i < 300 && !done; i++) @(negedge clk);
            start = 1'b0;
        end
        for (i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("sweep_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic run_abort(input int a, input logic [15:0] f, input logic [15:0] m);
        exp_t e;
        int   seen;
        tb_f  = f;
        tb_m1 = m;
        tb_m2 = '0;
        tb_m3 = '0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (a - 1) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        e = model(f, m, (a - 1) / 2, cyc);
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_dcba",  32'(dcba), 32'd0);
        check("abort_pass",  32'(pass), 32'd0);
        check("abort_truth", 32'(truth), 32'(e.truth));
        check("abort_err",   32'(err_cnt), 32'(e.errs));
        check("abort_fvld",  32'(first_err_vld), 32'(e.fvld));
        check("abort_fvec",  32'(first_err_vec), 32'(e.fvec));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);
    endtask

    initial begin
        logic [15:0] xor_f;
        logic [15:0] m;
        int          a;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        tb_f  = '0;
        tb_m1 = '0;
        tb_m2 = '0;
        tb_m3 = '0;
        for (int v = 0; v < 16; v++) xor_f[v] = v[0] ^ v[3];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        run_sweep(xor_f, '0, '0, '0, 1'b0);
        run_sweep(xor_f, '0, '0, 16'h0220, 1'b0);
        run_sweep(xor_f, '0, '0, '0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            run_sweep(16'($urandom), 16'($urandom & $urandom & $urandom), 16'($urandom & $urandom & $urandom),
                      16'($urandom & $urandom & $urandom), 1'b0);
        end
        run_sweep(16'($urandom), 16'hFFFF, 16'($urandom), '0, 1'b0);

`ifdef COMB_SWEEP_STOP_ON_ERR_EN
        m = '0;
`else
        m = 16'($urandom & $urandom);
`endif
        run_abort(11, xor_f, m);
        for (int n = 0; n < 2; n++) begin
            a = 1 + 2 * int'($urandom_range(0, 15));
            run_abort(a, 16'($urandom), m);
        end

        tb_f  = xor_f;
        tb_m1 = '0;
        tb_m2 = '0;
        tb_m3 = '0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");
        run_sweep(xor_f, '0, '0, '0, 1'b0);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
